modinv_unit: RTL and testbench

- Parametrised successor to the fixed-width n0prime block.
- One iterative engine serving the RSA datapath in two modes:
  - CRT mode: modular inverse a^-1 mod m, e.g. qinv = q^-1 mod p.
  - Montgomery mode: word-level n0' = -m^-1 mod 2^NPW.
- Handles any a (including a >= m), flags non-invertible or illegal operands, and uses a start/busy/done handshake.
- Feeds the CRT recombination stage and the Montgomery multiplier constant registers.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/modhalf_sub.sv | 39 +++
 rtl/modinv_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_modinv_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath helper blocks: FSM states and
// operating-mode encodings used by the modular-inverse engine.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_EUCLID = 3'd2,
        ST_MONT   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam logic MODE_CRT  = 1'b0;
    localparam logic MODE_MONT = 1'b1;

endpackage

// File: rtl/modhalf_sub.sv
// Combinational modular update for one Bezout coefficient of the binary
// extended Euclid loop. halve = 1: x/2 mod m (adds m first when x is odd,
// in W+1 bits so the carry survives the shift). halve = 0: x - y mod m
// (adds m back on borrow). Inputs are assumed to lie in [0, m).
module modhalf_sub #(
    parameter int W = 512
) (
    input  logic         halve,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] m,
    output logic [W-1:0] r
);

    logic [W:0] sum_s;

    // Select between modular halving and modular subtraction of x and y
    always_comb begin
        sum_s = {(W+1){1'b0}};
        r     = {W{1'b0}};
        if (halve) begin
            if (x[0]) begin
                sum_s = {1'b0, x} + {1'b0, m};
            end else begin
                sum_s = {1'b0, x};
            end
            r = sum_s[W:1];
        end else begin
            sum_s = {1'b0, x} - {1'b0, y};
            if (sum_s[W]) begin
                // negative difference: low W bits hold x-y+2^W, adding m wraps into [0, m)
                r = sum_s[W-1:0] + m;
            end else begin
                r = sum_s[W-1:0];
            end
        end
    end

endmodule

// File: rtl/modinv_unit.sv
// Iterative modular-inverse engine for the RSA datapath.
//   mode 0 (CRT):  result = a^-1 mod m via binary extended Euclid.
//   mode 1 (MONT): result = -m^-1 mod 2^NPW via Hensel lifting, zero-extended.
// Illegal operands (m even, 0 or 1; a == 0 in mode 0) and gcd(a, m) != 1
// are reported through err with result forced to zero.
module modinv_unit
    import rsa_pkg::*;
#(
    parameter int W    = 512,
    parameter int NPW  = 64,
    parameter int CNTW = $clog2(4*W+4)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         err
);

    localparam logic [W-1:0]    ZERO_W    = {W{1'b0}};
    localparam logic [W-1:0]    ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [NPW-1:0]  ONE_NPW   = {{(NPW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] ZERO_CNT  = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] ONE_CNT   = {{(CNTW-1){1'b0}}, 1'b1};
    // last Euclid cycle allowed: 4*W+2 cycles are numbered 0 .. 4*W+1
    localparam logic [CNTW-1:0] STEP_LAST = CNTW'(4*W+1);
    localparam logic [CNTW-1:0] MONT_LAST = CNTW'(NPW-1);

    state_e          state_r;
    logic            mode_r;
    logic [W-1:0]    m_r;
    logic [W-1:0]    u_r;
    logic [W-1:0]    v_r;
    logic [W-1:0]    x1_r;
    logic [W-1:0]    x2_r;
    logic [CNTW-1:0] cnt_r;
    logic [NPW-1:0]  y_r;
    logic [NPW-1:0]  pr_r;

    logic            u_even_s;
    logic            v_even_s;
    logic            u_ge_v_s;
    logic            bad_operand_s;
    logic [W-1:0]    x1_next_s;
    logic [W-1:0]    x2_next_s;
    logic [NPW-1:0]  onehot_s;
    logic [NPW-1:0]  m_shift_s;
    logic            pr_hit_s;
    logic [NPW-1:0]  y_next_s;
    logic [NPW-1:0]  pr_next_s;
    logic [W-1:0]    mont_res_s;

    // Euclid step decode and operand legality check
    always_comb begin
        u_even_s      = ~u_r[0];
        v_even_s      = ~v_r[0];
        u_ge_v_s      = (u_r >= v_r);
        bad_operand_s = ~m_r[0] | (m_r == ONE_W) | ((mode_r == MODE_CRT) && (u_r == ZERO_W));
    end

    // x1 follows u: halved when u is even, otherwise x1 - x2
    modhalf_sub #(.W(W)) u_x1_upd (
        .halve (u_even_s),
        .x     (x1_r),
        .y     (x2_r),
        .m     (m_r),
        .r     (x1_next_s)
    );

    // x2 follows v: halved when v is even, otherwise x2 - x1
    modhalf_sub #(.W(W)) u_x2_upd (
        .halve (v_even_s),
        .x     (x2_r),
        .y     (x1_r),
        .m     (m_r),
        .r     (x2_next_s)
    );

    // Hensel lifting step: clear bit i of m*y by adding m<<i, recording bit i in y
    always_comb begin
        onehot_s  = ONE_NPW << cnt_r;
        m_shift_s = m_r[NPW-1:0] << cnt_r;
        pr_hit_s  = |(pr_r & onehot_s);
        if (pr_hit_s) begin
            y_next_s  = y_r | onehot_s;
            pr_next_s = pr_r + m_shift_s;
        end else begin
            y_next_s  = y_r;
            pr_next_s = pr_r;
        end
        mont_res_s             = ZERO_W;
        mont_res_s[NPW-1:0]    = ~y_next_s + ONE_NPW;
    end

    // Control FSM with registered handshake outputs and iteration datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= ZERO_W;
            mode_r  <= MODE_CRT;
            m_r     <= ZERO_W;
            u_r     <= ZERO_W;
            v_r     <= ZERO_W;
            x1_r    <= ZERO_W;
            x2_r    <= ZERO_W;
            cnt_r   <= ZERO_CNT;
            y_r     <= ONE_NPW;
            pr_r    <= {NPW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        mode_r  <= mode;
                        m_r     <= m;
                        u_r     <= a;
                        v_r     <= m;
                        x1_r    <= ONE_W;
                        x2_r    <= ZERO_W;
                        cnt_r   <= ZERO_CNT;
                        y_r     <= ONE_NPW;
                        pr_r    <= m[NPW-1:0];
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_CHECK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_CHECK: begin
                    if (bad_operand_s) begin
                        err     <= 1'b1;
                        result  <= ZERO_W;
                        done    <= 1'b1;
                        state_r <= ST_FINISH;
                    end else if (mode_r == MODE_CRT) begin
                        cnt_r   <= ZERO_CNT;
                        state_r <= ST_EUCLID;
                    end else begin
                        // bit 0 of m*y is already 1 for odd m, lifting starts at bit 1
                        cnt_r   <= ONE_CNT;
                        state_r <= ST_MONT;
                    end
                end

                ST_EUCLID: begin
                    if ((u_r == ZERO_W) || (v_r == ZERO_W)) begin
                        // gcd(a, m) != 1
                        err     <= 1'b1;
                        result  <= ZERO_W;
                        done    <= 1'b1;
                        state_r <= ST_FINISH;
                    end else if (u_r == ONE_W) begin
                        result  <= x1_r;
                        done    <= 1'b1;
                        state_r <= ST_FINISH;
                    end else if (v_r == ONE_W) begin
                        result  <= x2_r;
                        done    <= 1'b1;
                        state_r <= ST_FINISH;
                    end else if (cnt_r == STEP_LAST) begin
                        // iteration budget exhausted: datapath fault guard
                        err     <= 1'b1;
                        result  <= ZERO_W;
                        done    <= 1'b1;
                        state_r <= ST_FINISH;
                    end else begin
                        cnt_r <= cnt_r + ONE_CNT;
                        if (u_even_s) begin
                            u_r  <= u_r >> 1;
                            x1_r <= x1_next_s;
                        end else if (v_even_s) begin
                            v_r  <= v_r >> 1;
                            x2_r <= x2_next_s;
                        end else if (u_ge_v_s) begin
                            u_r  <= u_r - v_r;
                            x1_r <= x1_next_s;
                        end else begin
                            v_r  <= v_r - u_r;
                            x2_r <= x2_next_s;
                        end
                    end
                end

                ST_MONT: begin
                    y_r  <= y_next_s;
                    pr_r <= pr_next_s;
                    if (cnt_r == MONT_LAST) begin
                        result  <= mont_res_s;
                        done    <= 1'b1;
                        state_r <= ST_FINISH;
                    end else begin
                        cnt_r <= cnt_r + ONE_CNT;
                    end
                end

                ST_FINISH: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_unit.sv
// Bench for modinv_unit: a W=16/NPW=8 instance for directed and random
// cases, and a W=512/NPW=64 instance for wide random operands. Expected
// values come from a plain-arithmetic extended Euclid (division based) and
// a Newton-iteration inverse modulo 2^64.
module tb_modinv_unit;

    logic clk = 1'b0;
    logic rst_n;

    logic        s16_start, s16_mode, s16_busy, s16_done, s16_err;
    logic [15:0] s16_a, s16_m, s16_result;

    logic         s512_start, s512_mode, s512_busy, s512_done, s512_err;
    logic [511:0] s512_a, s512_m, s512_result;

    int checks   = 0;
    int failures = 0;

    modinv_unit #(.W(16), .NPW(8)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (s16_start),
        .mode   (s16_mode),
        .a      (s16_a),
        .m      (s16_m),
        .busy   (s16_busy),
        .done   (s16_done),
        .result (s16_result),
        .err    (s16_err)
    );

    modinv_unit #(.W(512), .NPW(64)) dut512 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (s512_start),
        .mode   (s512_mode),
        .a      (s512_a),
        .m      (s512_m),
        .busy   (s512_busy),
        .done   (s512_done),
        .result (s512_result),
        .err    (s512_err)
    );

    // free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // gcd and inverse by the textbook division-based extended Euclid
    function automatic void ref_inv(input logic [1023:0] av, input logic [1023:0] mv,
                                    output logic [1023:0] inv, output bit ok);
        logic [1023:0] r0, r1, t0, t1, q, tmp;
        r0 = mv;
        r1 = av % mv;
        t0 = 1024'd0;
        t1 = 1024'd1;
        for (int k = 0; k < 4000; k++) begin
            if (r1 == 1024'd0) break;
            q   = r0 / r1;
            tmp = r0 - q * r1;
            r0  = r1;
            r1  = tmp;
            tmp = (t0 + mv - ((q * t1) % mv)) % mv;
            t0  = t1;
            t1  = tmp;
        end
        ok  = (r0 == 1024'd1);
        inv = ok ? t0 : 1024'd0;
    endfunction

    // -m^-1 mod 2^npw via Newton iteration x <- x*(2 - m*x) in 64-bit arithmetic
    function automatic logic [63:0] ref_n0(input logic [63:0] mv, input int npw);
        logic [63:0] x, mask;
        x = mv;
        for (int k = 0; k < 6; k++) x = x * (64'd2 - mv * x);
        mask = (npw >= 64) ? {64{1'b1}} : ((64'd1 << npw) - 64'd1);
        return (~x + 64'd1) & mask;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Issue one operation on the 16-bit instance; start is driven at call time.
    // glitch_at > 0 raises start with different operands while busy.
    task automatic run16(input logic md, input logic [15:0] av, input logic [15:0] mv, input int glitch_at,
                         output logic [15:0] res, output logic er, output int lat);
        bit seen;
        s16_start = 1'b1; s16_mode = md; s16_a = av; s16_m = mv;
        seen = 1'b0; lat = 0; res = 16'd0; er = 1'b0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(posedge clk); #1;
            s16_start = (c == glitch_at);
            if (c == glitch_at) begin
                s16_a = 16'd5; s16_m = 16'd61; s16_mode = 1'b1;
            end
            if (s16_done) begin
                seen = 1'b1; lat = c + 1; res = s16_result; er = s16_err;
                check_val("busy_at_done16", s16_busy, 1'b1);
            end
        end
        check_val("done_seen16", seen, 1'b1);
    endtask

    task automatic run512(input logic md, input logic [511:0] av, input logic [511:0] mv,
                          output logic [511:0] res, output logic er, output int lat);
        bit seen;
        s512_start = 1'b1; s512_mode = md; s512_a = av; s512_m = mv;
        seen = 1'b0; lat = 0; res = 512'd0; er = 1'b0;
        for (int c = 1; c <= 2100 && !seen; c++) begin
            @(posedge clk); #1;
            s512_start = 1'b0;
            if (s512_done) begin
                seen = 1'b1; lat = c + 1; res = s512_result; er = s512_err;
            end
        end
        check_val("done_seen512", seen, 1'b1);
    endtask

    // move from the FINISH cycle to the negedge of the following IDLE cycle
    task automatic to_idle();
        repeat (2) @(negedge clk);
    endtask

    logic [15:0]   r16;
    logic [511:0]  r512, a512, m512;
    logic [1023:0] exp_inv;
    logic          e;
    int            lat;
    bit            ok;
    bit            seen_done;

    initial begin
        rst_n = 1'b0;
        s16_start = 1'b0; s16_mode = 1'b0; s16_a = 16'd0; s16_m = 16'd0;
        s512_start = 1'b0; s512_mode = 1'b0; s512_a = 512'd0; s512_m = 512'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", s16_busy, 1'b0);
        check_val("rst_done", s16_done, 1'b0);
        check_val("rst_err", s16_err, 1'b0);
        check_val("rst_result", s16_result, 16'd0);
        check_val("rst_result512", s512_result, 512'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // a > m CRT inverse
        run16(1'b0, 16'd97, 16'd59, 0, r16, e, lat);
        check_val("crt97_res", r16, 16'd14);
        check_val("crt97_err", e, 1'b0);
        check_val("crt97_lat_le69", (lat <= 69), 1'b1);
        @(posedge clk); #1;
        check_val("done_one_cycle", s16_done, 1'b0);
        check_val("busy_drop", s16_busy, 1'b0);
        @(negedge clk);

        // Montgomery n0'
        run16(1'b1, 16'd0, 16'd97, 0, r16, e, lat);
        check_val("mont97_res", r16, 16'h005F);
        check_val("mont97_err", e, 1'b0);
        check_val("mont97_lat", lat, 10);
        to_idle();

        // even modulus rejected in CHECK
        run16(1'b0, 16'd7, 16'd60, 0, r16, e, lat);
        check_val("m60_err", e, 1'b1);
        check_val("m60_res", r16, 16'd0);
        check_val("m60_lat", lat, 3);
        to_idle();

        // m == 1 rejected in mode 1
        run16(1'b1, 16'd7, 16'd1, 0, r16, e, lat);
        check_val("m1_err", e, 1'b1);
        check_val("m1_lat", lat, 3);
        to_idle();

        // a == 0 rejected in mode 0
        run16(1'b0, 16'd0, 16'd59, 0, r16, e, lat);
        check_val("a0_err", e, 1'b1);
        check_val("a0_lat", lat, 3);
        to_idle();

        // gcd 59 detected during Euclid
        run16(1'b0, 16'd118, 16'd59, 0, r16, e, lat);
        check_val("gcd59_err", e, 1'b1);
        check_val("gcd59_res", r16, 16'd0);
        check_val("gcd59_from_euclid", (lat > 3), 1'b1);
        to_idle();

        // a == 1, then back-to-back start in the first IDLE cycle
        run16(1'b0, 16'd1, 16'd59, 0, r16, e, lat);
        check_val("a1_res", r16, 16'd1);
        @(posedge clk); #1;
        run16(1'b0, 16'd58, 16'd59, 0, r16, e, lat);
        check_val("b2b_res", r16, 16'd58);
        check_val("b2b_err", e, 1'b0);
        to_idle();

        // reset mid-operation
        s16_start = 1'b1; s16_mode = 1'b0; s16_a = 16'd97; s16_m = 16'd59;
        @(posedge clk); #1;
        s16_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("midrst_busy", s16_busy, 1'b0);
        check_val("midrst_done", s16_done, 1'b0);
        check_val("midrst_result", s16_result, 16'd0);
        check_val("midrst_err", s16_err, 1'b0);
        seen_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (s16_done) seen_done = 1'b1;
        end
        check_val("midrst_no_done", seen_done, 1'b0);
        @(negedge clk);

        // start pulsed while busy is ignored
        run16(1'b0, 16'd97, 16'd59, 3, r16, e, lat);
        check_val("busy_start_res", r16, 16'd14);
        check_val("busy_start_err", e, 1'b0);
        check_val("busy_start_idle", s16_busy, 1'b1);
        to_idle();
        check_val("busy_start_not_taken", s16_busy, 1'b0);

        // random 16-bit CRT operands
        for (int t = 0; t < 10; t++) begin
            logic [15:0] ra, rm;
            ra = 16'($urandom);
            rm = 16'($urandom) | 16'd1;
            if (rm == 16'd1) rm = 16'd3;
            if (ra == 16'd0) begin
                ok = 1'b0; exp_inv = 1024'd0;
            end else begin
                ref_inv({1008'd0, ra}, {1008'd0, rm}, exp_inv, ok);
            end
            run16(1'b0, ra, rm, 0, r16, e, lat);
            check_val("rnd16_res", r16, exp_inv);
            check_val("rnd16_err", e, !ok);
            check_val("rnd16_lat", (lat <= 69), 1'b1);
            to_idle();
        end

        // random 16-bit Montgomery operands
        for (int t = 0; t < 4; t++) begin
            logic [15:0] rm;
            rm = 16'($urandom) | 16'd1;
            if (rm == 16'd1) rm = 16'd5;
            run16(1'b1, 16'($urandom), rm, 0, r16, e, lat);
            check_val("rnd16_n0", r16, ref_n0({48'd0, rm}, 8));
            check_val("rnd16_n0_lat", lat, 10);
            to_idle();
        end

        // wide random CRT operands with gcd 1
        for (int t = 0; t < 5; t++) begin
            m512 = rand512() | 512'd1;
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                a512 = rand512();
                ref_inv({512'd0, a512}, {512'd0, m512}, exp_inv, ok);
            end
            run512(1'b0, a512, m512, r512, e, lat);
            check_val("rnd512_res", r512, exp_inv);
            check_val("rnd512_err", e, 1'b0);
            check_val("rnd512_lat", (lat <= 4*512+5), 1'b1);
            to_idle();
        end

        // wide random Montgomery operands
        for (int t = 0; t < 2; t++) begin
            m512 = rand512() | 512'd1;
            run512(1'b1, rand512(), m512, r512, e, lat);
            check_val("rnd512_n0", r512, ref_n0(m512[63:0], 64));
            check_val("rnd512_n0_lat", lat, 66);
            to_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
